// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter sharing a single TDP36K BRAM port.
// Define BRAM_ARB_CLEAR_EN to zero the whole BRAM after every reset before requests are served.
module bram_port_arbiter #(
    parameter int ABITS = 10,
    parameter int DBITS = 18
) (
    input  logic                 CLK_i,
    input  logic                 RESET_ni,
    input  logic [1:0]           REQ_i,
    input  logic [1:0]           WE_i,
    input  logic [2*ABITS-1:0]   ADDR_i,
    input  logic [2*DBITS-1:0]   WDATA_i,
    input  logic [3:0]           BE_i,
    output logic [1:0]           GNT_o,
    output logic [1:0]           RVALID_o,
    output logic [DBITS-1:0]     RDATA_o,
    output logic                 READY_o,
    output logic [ABITS-1:0]     BRAM_ADDR_o,
    output logic [DBITS-1:0]     BRAM_WDATA_o,
    output logic [1:0]           BRAM_BE_o,
    output logic                 BRAM_REN_o,
    output logic                 BRAM_WEN_o,
    input  logic [DBITS-1:0]     BRAM_RDATA_i
);

`ifdef BRAM_ARB_CLEAR_EN
    typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;
    localparam state_t RST_STATE = CLEAR;
    localparam logic [ABITS-1:0] CLR_LAST = {ABITS{1'b1}};
    localparam logic [ABITS-1:0] CLR_STEP = {{(ABITS-1){1'b0}}, 1'b1};
`else
    typedef enum logic {SERVE = 1'b1} state_t;
    localparam state_t RST_STATE = SERVE;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic               r_pri;
    logic [1:0]         r_rvalid;
    logic [1:0]         w_gnt;
    logic               w_gnt_idx;
    logic               w_any_gnt;
    logic               w_sel_we;
    logic [ABITS-1:0]   w_sel_addr;
    logic [DBITS-1:0]   w_sel_wdata;
    logic [1:0]         w_sel_be;
`ifdef BRAM_ARB_CLEAR_EN
    logic [ABITS-1:0]   r_clr_addr;
    logic [ABITS-1:0]   w_clr_addr_nxt;
`endif

    // Grant: a lone requester always wins; under contention r_pri picks the winner.
    always_comb begin
        w_gnt = 2'b00;
        if (r_ready && (r_state == SERVE)) begin
            case (REQ_i)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_pri ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end else begin
            w_gnt = 2'b00;
        end
    end

    assign w_gnt_idx = w_gnt[1];
    assign w_any_gnt = |w_gnt;

    // Select the granted requester's command fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = 2'b00;
        if (w_gnt_idx) begin
            w_sel_we    = WE_i[1];
            w_sel_addr  = ADDR_i[ABITS +: ABITS];
            w_sel_wdata = WDATA_i[DBITS +: DBITS];
            w_sel_be    = BE_i[3:2];
        end else begin
            w_sel_we    = WE_i[0];
            w_sel_addr  = ADDR_i[0 +: ABITS];
            w_sel_wdata = WDATA_i[0 +: DBITS];
            w_sel_be    = BE_i[1:0];
        end
    end

    // BRAM port drive; the clear-sweep write is held off while reset is asserted.
    always_comb begin
        BRAM_ADDR_o  = '0;
        BRAM_WDATA_o = '0;
        BRAM_BE_o    = 2'b00;
        BRAM_REN_o   = 1'b0;
        BRAM_WEN_o   = 1'b0;
        case (r_state)
`ifdef BRAM_ARB_CLEAR_EN
            CLEAR: begin
                BRAM_ADDR_o = r_clr_addr;
                BRAM_BE_o   = 2'b11;
                BRAM_WEN_o  = RESET_ni;
            end
`endif
            SERVE: begin
                if (w_any_gnt) begin
                    BRAM_ADDR_o  = w_sel_addr;
                    BRAM_WDATA_o = w_sel_wdata;
                    BRAM_BE_o    = w_sel_be;
                    BRAM_WEN_o   = w_sel_we;
                    BRAM_REN_o   = ~w_sel_we;
                end else begin
                    BRAM_REN_o   = 1'b0;
                    BRAM_WEN_o   = 1'b0;
                end
            end
            default: begin
                BRAM_REN_o = 1'b0;
                BRAM_WEN_o = 1'b0;
            end
        endcase
    end

    // Next state: the sweep leaves CLEAR right after writing the last address.
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = r_ready;
`ifdef BRAM_ARB_CLEAR_EN
        w_clr_addr_nxt = r_clr_addr;
`endif
        case (r_state)
`ifdef BRAM_ARB_CLEAR_EN
            CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + CLR_STEP;
                if (r_clr_addr == CLR_LAST) begin
                    w_state_nxt = SERVE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = CLEAR;
                    w_ready_nxt = 1'b0;
                end
            end
`endif
            SERVE: begin
                w_state_nxt = SERVE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State, priority pointer and one-cycle read-valid pipeline.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            r_state    <= RST_STATE;
            r_ready    <= 1'b0;
            r_pri      <= 1'b0;
            r_rvalid   <= 2'b00;
`ifdef BRAM_ARB_CLEAR_EN
            r_clr_addr <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            if (w_any_gnt) begin
                r_pri <= ~w_gnt_idx;
            end
            r_rvalid   <= w_gnt & ~WE_i;
`ifdef BRAM_ARB_CLEAR_EN
            r_clr_addr <= w_clr_addr_nxt;
`endif
        end
    end

    assign GNT_o    = w_gnt;
    assign RVALID_o = r_rvalid;
    assign READY_o  = r_ready;
    assign RDATA_o  = (|r_rvalid) ? BRAM_RDATA_i : '0;

endmodule
